// File: rtl/als_pkg.sv
// Shared types and constants for the ambient-light display path.
package als_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Active-low gfedcba segment patterns.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All anodes off (active-low).
  localparam logic [3:0] AN_OFF = 4'hF;

  // Map one BCD digit to its segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// start is honoured only when idle; bin is sampled in the LOAD cycle, and
// bcd holds the final result from the DONE cycle until the next LOAD.
module bin2bcd_seq
  import als_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  state_t      state_q, state_d;
  logic [19:0] shreg_q, shreg_d;   // {hundreds, tens, units, binary}
  logic [2:0]  cnt_q, cnt_d;

  // State, shift register and bit counter.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath: load, eight adjust-and-shift steps, done.
  // NOTE: every output of this block is given a default first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        shreg_d = {12'd0, bin};
        cnt_d   = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {dabble_adjust(shreg_q[19:8]), shreg_q[7:0]} << 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = shreg_q[19:8];

endmodule

// File: rtl/als_display.sv
// PmodALS consumer: synchronises read_flag, averages the last 2^AVG_LOG2
// samples, converts the average to BCD and multiplexes a 4-digit display.
module als_display
  import als_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       read_flag,
  output logic [7:0] value,
  output logic       value_valid,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 8 + AVG_LOG2;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic f1, f2, f3;
  logic rise;

  logic [7:0]          samp_q [DEPTH];
  logic [SUM_W-1:0]    sum_q;
  logic [AVG_LOG2-1:0] idx_q;
  logic [7:0]          avg;

  logic        pending_q;
  logic        start, busy, done;
  logic [11:0] bcd;

  logic [7:0] value_q;
  logic [3:0] hund_q, tens_q, units_q;

  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       digit_q;
  logic [6:0]       seg_q, seg_nx;
  logic [3:0]       an_q, an_nx;

  // Three-flop chain on read_flag; a capture is the first cycle f2 is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {f3, f2, f1} <= 3'b000;
    else        {f3, f2, f1} <= {f2, f1, read_flag};
  end

  assign rise = f2 & ~f3;

  // Running sum over a circular sample buffer; data is stable by the time
  // the synchronised flag rises, so it is taken directly.
  // NOTE: the sample buffer is reset because the average deliberately ramps
  // up from zero after reset; a RAM without reset would start from garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) samp_q[i] <= '0;
      sum_q <= '0;
      idx_q <= '0;
    end else if (rise) begin
      samp_q[idx_q] <= data;
      sum_q         <= sum_q - SUM_W'(samp_q[idx_q]) + SUM_W'(data);
      idx_q         <= idx_q + AVG_LOG2'(1);
    end
  end

  assign avg = sum_q[SUM_W-1:AVG_LOG2];

  // Remember a capture that arrives while a conversion is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pending_q <= 1'b0;
    else if (rise && busy) pending_q <= 1'b1;
    else if (start)        pending_q <= 1'b0;
  end

  assign start = ~busy & (rise | pending_q);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (avg),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // Publish the average and its digits when a conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
    end else if (done) begin
      value_q <= avg;
      hund_q  <= bcd[11:8];
      tens_q  <= bcd[7:4];
      units_q <= bcd[3:0];
    end
  end

  // Segment/anode pattern for the digit about to be shown; leading zeros blank.
  always_comb begin
    seg_nx = SEG_BLANK;
    an_nx  = AN_OFF ^ (4'b0001 << digit_q);
    case (digit_q)
      2'd0:    seg_nx = seg_of(units_q);
      2'd1:    if (hund_q != 4'd0 || tens_q != 4'd0) seg_nx = seg_of(tens_q);
      2'd2:    if (hund_q != 4'd0) seg_nx = seg_of(hund_q);
      default: seg_nx = SEG_BLANK;
    endcase
  end

  // Refresh timer; seg and an load together on wrap so digits never smear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      digit_q   <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      digit_q   <= digit_q + 2'd1;
      seg_q     <= seg_nx;
      an_q      <= an_nx;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  assign value       = value_q;
  assign value_valid = done;
  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = 1'b1;

endmodule

// File: tb/tb_als_display.sv
// Scoreboard bench for als_display: stimulus pushes expected results,
// an independent monitor pops and compares on every value_valid.
module tb_als_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'd0;
  logic       read_flag = 1'b0;
  logic [7:0] value;
  logic       value_valid;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  als_display #(.AVG_LOG2(2), .REFRESH_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .read_flag   (read_flag),
    .value       (value),
    .value_valid (value_valid),
    .seg         (seg),
    .an          (an),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         exp_cyc;
    logic [7:0] val;
    bit         care;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: timing checked on the valid cycle, value on the following cycle.
  initial begin : monitor
    bit         chk_val;
    logic [7:0] want;
    exp_t       e;
    chk_val = 1'b0;
    want    = 8'd0;
    forever begin
      @(negedge clk);
      if (chk_val) begin
        check("value", value, want);
        chk_val = 1'b0;
      end
      if (value_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid with value %0d at cycle %0d, expected none", value, cyc);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", cyc, e.exp_cyc);
          if (e.care) begin
            chk_val = 1'b1;
            want    = e.val;
          end
        end
      end
    end
  end

  // Called at a negedge: present a sample and hold the flag for 'hold' cycles.
  task automatic pulse(input logic [7:0] d, input int lat, input logic [7:0] exp_val,
                       input bit care, input int hold = 2);
    exp_t e;
    data      = d;
    read_flag = 1'b1;
    if (lat > 0) begin
      e.exp_cyc = cyc + lat;
      e.val     = exp_val;
      e.care    = care;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    read_flag = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Align to the start of digit 0, then check each digit over its 4 cycles.
  task automatic check_digits(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    logic [3:0] a;
    int n;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    n = 0;
    while (an == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (an != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL digit_sync: got an=%b, expected 1110 within 40 cycles", an);
      return;
    end
    for (int d = 0; d < 4; d++) begin
      a = 4'b1111 ^ (4'b0001 << d);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("an_digit%0d", d), an, a);
        check($sformatf("seg_digit%0d", d), seg, s[d]);
        @(negedge clk);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_value", value, 8'd0);
    check("rst_valid", value_valid, 1'b0);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_dp", dp, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single capture of 100 -> average 25.
    pulse(8'd100, 12, 8'd25, 1'b1);
    repeat (40) @(negedge clk);
    check_digits(7'h12, 7'h24, 7'h7F, 7'h7F);

    // Four captures of 200 from a cleared buffer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(8'd200, 12, 8'(50 * (i + 1)), 1'b1);
      repeat (38) @(negedge clk);
    end
    check_digits(7'h40, 7'h40, 7'h24, 7'h7F);

    // Second capture at C+4 is queued; its result follows 11 cycles later.
    do_reset();
    pulse(8'd100, 12, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    pulse(8'd80, 19, 8'd45, 1'b1);
    repeat (40) @(negedge clk);
    check_digits(7'h12, 7'h19, 7'h7F, 7'h7F);

    // Value 7: single digit, others blank.
    do_reset();
    pulse(8'd28, 12, 8'd7, 1'b1);
    repeat (40) @(negedge clk);
    check_digits(7'h78, 7'h7F, 7'h7F, 7'h7F);

    // Flag held high for 100 cycles: one capture, (28+40)/4 = 17.
    pulse(8'd40, 12, 8'd17, 1'b1, 100);
    repeat (40) @(negedge clk);
    check("hold_single_result", sb.size(), 0);
    check("hold_value", value, 8'd17);

    // Reset at C+5 of a conversion abandons it.
    pulse(8'd100, 0, 8'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_value", value, 8'd0);
    check("midrst_valid", value_valid, 1'b0);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_an", an, 4'hF);
    check("midrst_dp", dp, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    pulse(8'd100, 12, 8'd25, 1'b1);
    repeat (40) @(negedge clk);
    check_digits(7'h12, 7'h24, 7'h7F, 7'h7F);

    n = 0;
    while (sb.size() > 0 && n < 200) begin @(negedge clk); n++; end
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
